// File: rtl/fetch_branch_unit_pkg.sv
// Shared encodings for the fetch/branch stage: condition codes, flag groups,
// instruction field positions and flag bit indices.
package fetch_branch_unit_pkg;

    localparam logic [2:0] TF_Z      = 3'b000;
    localparam logic [2:0] TF_N      = 3'b001;
    localparam logic [2:0] TF_C      = 3'b010;
    localparam logic [2:0] TF_ALWAYS = 3'b011;
    localparam logic [2:0] TF_O      = 3'b100;
    localparam logic [2:0] TF_NZ     = 3'b101;
    localparam logic [2:0] TF_NN     = 3'b110;
    localparam logic [2:0] TF_NEVER  = 3'b111;

    localparam logic [2:0] RF_NONE = 3'b000;
    localparam logic [2:0] RF_ZN   = 3'b001;
    localparam logic [2:0] RF_ZNCO = 3'b010;
    localparam logic [2:0] RF_ZNC  = 3'b011;
    localparam logic [2:0] RF_ZNO  = 3'b100;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 24;

    localparam int FLAG_O = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    localparam logic [2:0] TYPE_JMP = 3'b000;
    localparam logic [2:0] TYPE_JR  = 3'b110;

    // Which FLAGS bits a flag-group code writes; reserved codes write nothing.
    function automatic logic [3:0] rf_mask(input logic [2:0] w_rf);
        logic [3:0] m;
        m = 4'b0000;
        case (w_rf)
            RF_ZN:   m = (4'b1 << FLAG_Z) | (4'b1 << FLAG_N);
            RF_ZNCO: m = 4'b1111;
            RF_ZNC:  m = (4'b1 << FLAG_Z) | (4'b1 << FLAG_N) | (4'b1 << FLAG_C);
            RF_ZNO:  m = (4'b1 << FLAG_Z) | (4'b1 << FLAG_N) | (4'b1 << FLAG_O);
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fetch_branch_unit_cond_eval.sv
// Branch condition evaluator: combinational decode of OP_TF against registered flags.
module cond_eval
    import fetch_branch_unit_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [2:0] op_tf_i,
    output logic       cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (op_tf_i)
            TF_Z:      cond_o = flags_i[FLAG_Z];
            TF_N:      cond_o = flags_i[FLAG_N];
            TF_C:      cond_o = flags_i[FLAG_C];
            TF_ALWAYS: cond_o = 1'b1;
            TF_O:      cond_o = flags_i[FLAG_O];
            TF_NZ:     cond_o = ~flags_i[FLAG_Z];
            TF_NN:     cond_o = ~flags_i[FLAG_N];
            TF_NEVER:  cond_o = 1'b0;
            default:   cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch/program-flow stage: PC, IR, FLAGS and LINK registers; one redirect per
// instruction, with type/op bypassed from IM_DATA during the fetch cycle.
module fetch_branch_unit
    import fetch_branch_unit_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [INSTR_W-1:0] im_data_i,
    input  logic               w_pc_i,
    input  logic [2:0]         op_tf_i,
    input  logic [2:0]         w_rf_i,
    input  logic [3:0]         alu_flags_i,
    input  logic [ADDR_W-1:0]  target_rb_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] ir_o,
    output logic [2:0]         type_o,
    output logic [4:0]         op_o,
    output logic [3:0]         flags_o,
    output logic [ADDR_W-1:0]  link_o,
    output logic               taken_o
);

    logic [ADDR_W-1:0]  pc_q, pc_d, link_q, link_d, target;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         flags_q, flags_d, wr_mask;
    logic               taken_q, done_q, done_d;
    logic               cond, tgt_vld, redirect;

    cond_eval u_cond_eval (
        .flags_i (flags_q),
        .op_tf_i (op_tf_i),
        .cond_o  (cond)
    );

    always_comb begin
        target  = '0;
        tgt_vld = 1'b0;
        case (ir_q[TYPE_MSB:TYPE_LSB])
            TYPE_JMP: begin target = ir_q[ADDR_W-1:0]; tgt_vld = 1'b1; end
            TYPE_JR:  begin target = target_rb_i;      tgt_vld = 1'b1; end
            default:  ;
        endcase
    end

    // OP_TF is held for two edges; done_q suppresses the second redirect.
    assign redirect = (op_tf_i != TF_NEVER) && cond && !done_q && tgt_vld;
    assign wr_mask  = rf_mask(w_rf_i);

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        link_d  = link_q;
        done_d  = done_q;
        flags_d = (flags_q & ~wr_mask) | (alu_flags_i & wr_mask);
        if (w_pc_i) begin
            ir_d   = im_data_i;
            pc_d   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            done_d = 1'b0;
        end
        if (redirect) begin
            pc_d   = target;
            link_d = pc_q;
            if (!w_pc_i) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            link_q  <= '0;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            link_q  <= link_d;
            taken_q <= redirect;
            done_q  <= done_d;
        end
    end

    assign pc_o    = pc_q;
    assign ir_o    = ir_q;
    assign flags_o = flags_q;
    assign link_o  = link_q;
    assign taken_o = taken_q;
    assign type_o  = w_pc_i ? im_data_i[TYPE_MSB:TYPE_LSB] : ir_q[TYPE_MSB:TYPE_LSB];
    assign op_o    = w_pc_i ? im_data_i[OP_MSB:OP_LSB]     : ir_q[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im;
    logic        w_pc;
    logic [2:0]  op_tf;
    logic [2:0]  w_rf;
    logic [3:0]  alu;
    logic [15:0] trb;
    logic [15:0] pc, link;
    logic [31:0] ir;
    logic [2:0]  typ;
    logic [4:0]  op;
    logic [3:0]  flags;
    logic        taken;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] m_pc, m_link;
    logic [31:0] m_ir;
    logic [3:0]  m_flags;
    logic        m_taken, m_done;
    bit          m_valid = 0;

    always #5 clk = ~clk;

    fetch_branch_unit #(.ADDR_W(16), .INSTR_W(32)) dut (
        .clk_i(clk), .reset_i(rst), .im_data_i(im), .w_pc_i(w_pc), .op_tf_i(op_tf),
        .w_rf_i(w_rf), .alu_flags_i(alu), .target_rb_i(trb), .pc_o(pc), .ir_o(ir),
        .type_o(typ), .op_o(op), .flags_o(flags), .link_o(link), .taken_o(taken)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition table: O=bit3, C=bit2, N=bit1, Z=bit0.
    function automatic bit cond_true(input logic [3:0] f, input logic [2:0] code);
        case (code)
            3'd0: return f[0];
            3'd1: return f[1];
            3'd2: return f[2];
            3'd3: return 1'b1;
            3'd4: return f[3];
            3'd5: return !f[0];
            3'd6: return !f[1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        logic [15:0] tgt;
        logic [3:0]  nf;
        bit          go;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_flags = 0; m_link = 0; m_taken = 0; m_done = 0;
        end else begin
            go = 0; tgt = 0;
            if (!m_done && cond_true(m_flags, op_tf)) begin
                if (m_ir[31:29] == 3'd0) begin go = 1; tgt = m_ir[15:0]; end
                else if (m_ir[31:29] == 3'd6) begin go = 1; tgt = trb; end
            end
            nf = m_flags;
            if (w_rf >= 3'd1 && w_rf <= 3'd4) begin
                nf[0] = alu[0];
                nf[1] = alu[1];
                if (w_rf == 3'd2 || w_rf == 3'd3) nf[2] = alu[2];
                if (w_rf == 3'd2 || w_rf == 3'd4) nf[3] = alu[3];
            end
            m_taken = go;
            if (go) m_link = m_pc;
            if (w_pc) m_ir = im;
            if (go) m_pc = tgt;
            else if (w_pc) m_pc = 16'((int'(m_pc) + 1) % 65536);
            if (w_pc) m_done = 0;
            else if (go) m_done = 1;
            m_flags = nf;
        end
        m_valid = 1;
    endtask

    task automatic compare_regs();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir", ir, m_ir);
        chk("flags", 32'(flags), 32'(m_flags));
        chk("link", 32'(link), 32'(m_link));
        chk("taken", 32'(taken), 32'(m_taken));
    endtask

    // Inputs are already driven; check bypass fields, clock once, check registers.
    task automatic step();
        #1;
        if (m_valid) begin
            chk("type", 32'(typ), 32'(w_pc ? im[31:29] : m_ir[31:29]));
            chk("op",   32'(op),  32'(w_pc ? im[28:24] : m_ir[28:24]));
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_regs();
    endtask

    task automatic idle();
        rst = 0; w_pc = 0; op_tf = 3'd7; w_rf = 3'd0; alu = 4'd0; trb = 16'd0;
    endtask

    task automatic fetch(input logic [31:0] word);
        idle(); w_pc = 1; im = word; step(); idle();
    endtask

    task automatic branch2(input logic [2:0] code, input logic [15:0] rb);
        idle(); op_tf = code; trb = rb; step(); step(); idle();
    endtask

    initial begin
        idle(); im = 32'h0;
        rst = 1; step(); step();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_taken", 32'(taken), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        idle();

        // Three fetches 4 cycles apart.
        fetch(32'h2A00_0001); step(); step(); step();
        chk("fetch1_pc", 32'(pc), 32'h1);
        fetch(32'h2B00_0002); step(); step(); step();
        fetch(32'h2C00_0003);
        chk("fetch3_pc", 32'(pc), 32'h3);
        chk("fetch3_ir", ir, 32'h2C00_0003);
        chk("fetch3_type", 32'(typ), 32'h1);
        chk("fetch3_op", 32'(op), 32'h0C);

        // Unconditional jump from PC=5, held for two edges.
        fetch(32'h1100_0000);
        fetch(32'h0000_0040);
        chk("jmp_pre_pc", 32'(pc), 32'h5);
        idle(); op_tf = 3'd3; step();
        chk("jmp_pc", 32'(pc), 32'h40);
        chk("jmp_link", 32'(link), 32'h5);
        chk("jmp_taken1", 32'(taken), 32'h1);
        step();
        chk("jmp_pc2", 32'(pc), 32'h40);
        chk("jmp_taken2", 32'(taken), 32'h0);
        idle();

        // Conditional on Z: not taken, then set Z, then taken.
        fetch(32'h0000_0080);
        branch2(3'd0, 16'h0);
        chk("bz_nt_pc", 32'(pc), 32'h41);
        idle(); w_rf = 3'd1; alu = 4'b0001; step(); idle();
        chk("bz_flags", 32'(flags), 32'h1);
        branch2(3'd0, 16'h0);
        chk("bz_t_pc", 32'(pc), 32'h80);
        chk("bz_t_link", 32'(link), 32'h41);

        // Flag groups.
        idle(); w_rf = 3'd2; alu = 4'b0000; step();
        w_rf = 3'd3; alu = 4'b1111; step();
        chk("rf_znc", 32'(flags), 32'h7);
        w_rf = 3'd4; alu = 4'b1000; step(); idle();
        chk("rf_zno", 32'(flags), 32'hC);

        // Register jump from PC=0x0010, then wrap from 0xFFFF.
        fetch(32'h0000_000F);
        branch2(3'd3, 16'h0);
        fetch(32'hC000_0000);
        chk("jr_pre_pc", 32'(pc), 32'h10);
        branch2(3'd3, 16'h1234);
        chk("jr_pc", 32'(pc), 32'h1234);
        chk("jr_link", 32'(link), 32'h10);
        fetch(32'hC000_0000);
        branch2(3'd3, 16'hFFFF);
        chk("wrap_pre_pc", 32'(pc), 32'hFFFF);
        fetch(32'h0000_0040);
        chk("wrap_pc", 32'(pc), 32'h0);

        // Reset wins over simultaneous fetch, redirect and flag write.
        idle(); rst = 1; w_pc = 1; op_tf = 3'd3; w_rf = 3'd2; alu = 4'hF; im = 32'h0000_0099;
        step(); idle();
        chk("rstov_pc", 32'(pc), 32'h0);
        chk("rstov_flags", 32'(flags), 32'h0);
        chk("rstov_taken", 32'(taken), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            w_pc  = ($urandom_range(0, 3) == 0);
            op_tf = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            w_rf  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            alu   = 4'($urandom_range(0, 15));
            trb   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       im = {3'b000, 29'($urandom)};
                1:       im = {3'b110, 29'($urandom)};
                default: im = 32'($urandom);
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
